// File: rtl/branch_resolver_if.sv
// Handshake/bus bundle between the branch source, the resolver and the fetch stage.
// The resolver uses the slave modport; the driving environment uses master.
interface branch_resolver_if #(
   parameter int WIDTH = 16,
   parameter int OFF_W = 8
);
   logic             flag_wr;
   logic             flag_in;
   logic             br_valid;
   logic             br_ready;
   logic [1:0]       br_cond;
   logic [WIDTH-1:0] br_pc;
   logic [OFF_W-1:0] br_off;
   logic             redir_valid;
   logic             redir_ready;
   logic [WIDTH-1:0] redir_pc;
   logic             redir_taken;
   logic             flag_q;
   logic [15:0]      taken_cnt;

   modport slave (
      input  flag_wr, flag_in, br_valid, br_cond, br_pc, br_off, redir_ready,
      output br_ready, redir_valid, redir_pc, redir_taken, flag_q, taken_cnt
   );

   modport master (
      output flag_wr, flag_in, br_valid, br_cond, br_pc, br_off, redir_ready,
      input  br_ready, redir_valid, redir_pc, redir_taken, flag_q, taken_cnt
   );
endinterface

// File: rtl/branch_resolver.sv
// Zero-flag recorder and conditional branch resolver issuing one redirect per accepted branch.
// Optional taken-branch counter enabled by defining BR_STATS_EN.
module branch_resolver #(
   parameter int WIDTH = 16,
   parameter int OFF_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   branch_resolver_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_FLAG = 2'd1,
      ISSUE     = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic                    zflag_q, zflag_d;
   logic [1:0]              cond_q, cond_d;
   logic [WIDTH-1:0]        pc_q, pc_d;
   logic signed [OFF_W-1:0] off_q, off_d;
   logic                    redir_valid_q, redir_valid_d;
   logic [WIDTH-1:0]        redir_pc_q, redir_pc_d;
   logic                    redir_taken_q, redir_taken_d;

   logic                    accept;
   logic                    handoff;
   logic                    resolve;
   logic [1:0]              res_cond;
   logic [WIDTH-1:0]        res_pc;
   logic signed [OFF_W-1:0] res_off;
   logic                    res_taken;

   function automatic logic taken_f(input logic [1:0] cond, input logic zf);
      logic t;
      case (cond)
         2'b00:   t = 1'b1;
         2'b01:   t = zf;
         2'b10:   t = ~zf;
         default: t = 1'b0;
      endcase
      return t;
   endfunction

   // Wraps modulo 2^WIDTH; no saturation on purpose.
   function automatic logic [WIDTH-1:0] target_f(input logic [WIDTH-1:0]        pc,
                                                 input logic signed [OFF_W-1:0] off,
                                                 input logic                    taken);
      logic signed [WIDTH-1:0] off_ext;
      off_ext = taken ? WIDTH'(off) : '0;
      return pc + WIDTH'(1) + $unsigned(off_ext);
   endfunction

   always_comb begin
      accept  = (state_q == IDLE) && bus.br_valid;
      handoff = (state_q == ISSUE) && bus.redir_ready;
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.br_valid) begin
               state_d = bus.flag_wr ? WAIT_FLAG : ISSUE;
            end
         end
         WAIT_FLAG: state_d = ISSUE;
         ISSUE: begin
            if (bus.redir_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output decode: br_ready depends on the state register only
   always_comb begin
      bus.br_ready = (state_q == IDLE);
   end

   assign bus.redir_valid = redir_valid_q;
   assign bus.redir_pc    = redir_pc_q;
   assign bus.redir_taken = redir_taken_q;
   assign bus.flag_q      = zflag_q;

   // A coincident flag write defers resolution to WAIT_FLAG, where the
   // captured request meets the freshly written flag.
   always_comb begin
      zflag_d  = bus.flag_wr ? bus.flag_in : zflag_q;
      cond_d   = accept ? bus.br_cond : cond_q;
      pc_d     = accept ? bus.br_pc : pc_q;
      off_d    = accept ? $signed(bus.br_off) : off_q;

      resolve  = (accept && !bus.flag_wr) || (state_q == WAIT_FLAG);
      res_cond = (state_q == WAIT_FLAG) ? cond_q : bus.br_cond;
      res_pc   = (state_q == WAIT_FLAG) ? pc_q : bus.br_pc;
      res_off  = (state_q == WAIT_FLAG) ? off_q : $signed(bus.br_off);
      res_taken = taken_f(res_cond, zflag_q);

      redir_valid_d = redir_valid_q;
      if (resolve) begin
         redir_valid_d = 1'b1;
      end else if (handoff) begin
         redir_valid_d = 1'b0;
      end
      redir_pc_d    = resolve ? target_f(res_pc, res_off, res_taken) : redir_pc_q;
      redir_taken_d = resolve ? res_taken : redir_taken_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         zflag_q       <= 1'b0;
         redir_valid_q <= 1'b0;
         redir_pc_q    <= '0;
         redir_taken_q <= 1'b0;
      end else begin
         zflag_q       <= zflag_d;
         redir_valid_q <= redir_valid_d;
         redir_pc_q    <= redir_pc_d;
         redir_taken_q <= redir_taken_d;
      end
   end

   // Captured request fields are only read after a valid accept, so they carry no reset.
   always_ff @(posedge clk) begin
      cond_q <= cond_d;
      pc_q   <= pc_d;
      off_q  <= off_d;
   end

`ifdef BR_STATS_EN
   logic [15:0] taken_cnt_q, taken_cnt_d;

   always_comb begin
      taken_cnt_d = (handoff && redir_taken_q) ? taken_cnt_q + 16'd1 : taken_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         taken_cnt_q <= 16'd0;
      end else begin
         taken_cnt_q <= taken_cnt_d;
      end
   end

   assign bus.taken_cnt = taken_cnt_q;
`else
   assign bus.taken_cnt = 16'd0;
`endif

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Consumer side of the ALU zero-flag path: records the zero flag whenever the datapath signals a flag-writing operation, then resolves conditional branches against it. For each accepted branch request it issues one redirect (next PC plus taken bit) to the fetch stage over a valid/ready handshake. It sits between the ALU flag output and the PC-update logic of the 16-bit datapath.

## Interface
- WIDTH, 16, PC/address width
- OFF_W, 8, branch offset width (two's complement)

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- flag_wr  input  1  ALU op this cycle writes the zero flag
- flag_in  input  1  zero flag value, valid when flag_wr=1
- br_valid  input  1  branch request present
- br_ready  output  1  block can accept a request
- br_cond  input  2  00 always, 01 if zero, 10 if not zero, 11 never
- br_pc  input  WIDTH  PC of the branch instruction
- br_off  input  OFF_W  signed word offset
- redir_valid  output  1  redirect available
- redir_ready  input  1  fetch stage accepts redirect
- redir_pc  output  WIDTH  next PC
- redir_taken  output  1  branch was taken
- flag_q  output  1  currently recorded zero flag
- taken_cnt  output  16  taken-branch count (only with BR_STATS_EN; otherwise tied to 0)

## Operation
- Flag register: flag_q <= flag_in on every cycle with flag_wr=1, independent of FSM state.
- FSM states: IDLE, WAIT_FLAG, ISSUE.
- IDLE: br_ready=1. On br_valid=1, capture br_cond, br_pc, br_off.
  - If flag_wr=0 that cycle: resolve against flag_q and go to ISSUE.
  - If flag_wr=1 that cycle: go to WAIT_FLAG. Resolution must use the new flag, not the stale flag_q.
- WAIT_FLAG: br_ready=0. Resolve against flag_q (now updated) and go to ISSUE after exactly one cycle.
  - A further flag_wr in this cycle does not extend the wait; the resolution uses the value flag_q held entering WAIT_FLAG.
- ISSUE: br_ready=0, redir_valid=1.
  - redir_pc and redir_taken are stable until the cycle where redir_ready=1, then go to IDLE.
  - No new request is accepted in the handoff cycle.
- Taken decision:
  - cond 00 → 1
  - cond 01 → flag
  - cond 10 → ~flag
  - cond 11 → 0
- Target arithmetic:
  - Taken: br_pc + 1 + sign_extend(br_off).
  - Not taken: br_pc + 1.
  - All arithmetic is modulo 2^WIDTH, so wrap-around is silent. Examples: 0xFFFF+1 → 0x0000; 0x0000+1+(-2) → 0xFFFF.

## Timing
- Reset values: state=IDLE, flag_q=0, redir_valid=0, redir_pc=0, redir_taken=0, br_ready=1 (combinational from IDLE), taken_cnt=0.
- Latency from accept to redir_valid:
  - 1 cycle without a coincident flag_wr.
  - 2 cycles with one.
- Throughput: at best one branch per 2 cycles (accept, issue/handoff).
- Outputs redir_* are registered. br_ready is a decode of the state register only, with no combinational path from inputs.
- Reset asserted mid-operation: the pending request is dropped, redir_valid=0 on the next edge, and flag_q is cleared.
- flag_wr while in ISSUE updates flag_q but does not alter the already-resolved redirect.

## Configuration
- BR_STATS_EN defined:
  - taken_cnt is a 16-bit counter that increments on each ISSUE→IDLE handoff with redir_taken=1.
  - Wraps 0xFFFF→0x0000; cleared by reset.
- BR_STATS_EN undefined: no counter register exists and taken_cnt is driven constant 0.

## Test plan
- Reset, then flag_wr=1/flag_in=1; next cycle br_valid with cond=01, pc=0x0010, off=0x05, redir_ready=1 → redir_valid one cycle after accept, redir_pc=0x0016, redir_taken=1.
- flag_q=0; br_valid with cond=01 in the same cycle as flag_wr=1/flag_in=1, pc=0x0100, off=0xFE → WAIT_FLAG for one cycle, then redir_pc=0x00FF, taken=1 (2-cycle latency).
- cond=10 with flag_q=1, pc=0xFFFF → not taken, redir_pc=0x0000 (wrap).
- Hold redir_ready=0 for 5 cycles in ISSUE while toggling flag_wr/flag_in and br_valid → redir_pc/taken unchanged, br_ready=0 throughout; accepted on the first redir_ready=1.
- Assert reset in WAIT_FLAG → next cycle redir_valid=0, br_ready=1, flag_q=0.
- With BR_STATS_EN, 3 taken (cond=00) and 2 untaken (cond=11) branches → taken_cnt=3; without the macro → taken_cnt=0.
